// File: rtl/leaf_fetch_pkg.sv
// Shared types for the leaf fetch arbiter: FSM states, lane ids and the
// default-width lane FIFO entry layout.
package leaf_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_QID_WIDTH     = 12;

    // The top re-declares this layout with its own parameter widths.
    typedef struct packed {
        logic [DEF_QID_WIDTH-1:0]     qid;
        logic [DEF_ADDRESS_WIDTH-1:0] leaf_index;
    } leaf_entry_t;

endpackage

// File: rtl/leaf_idx_fifo.sv
// Synchronous first-word-fall-through FIFO with sticky drop flag and clear.
// Push while full is accepted only if a pop happens in the same cycle.
module leaf_idx_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/leaf_fetch_arbiter.sv
// Buffers two leaf-index lanes and round-robins them onto one leaf memory port.
// Enable-to-out_valid is 3 cycles; a record holds in HOLD until out_ready, upstream never stalls.
module leaf_fetch_arbiter
    import leaf_fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int LEAF_DATA_WIDTH = 64,
    parameter int QID_WIDTH       = 12,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       receiver_en,
    input  logic [ADDRESS_WIDTH-1:0]   leaf_index,
    input  logic                       receiver_two_en,
    input  logic [ADDRESS_WIDTH-1:0]   leaf_index_two,
    output logic                       leaf_ren,
    output logic [ADDRESS_WIDTH-1:0]   leaf_addr,
    input  logic [LEAF_DATA_WIDTH-1:0] leaf_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_lane,
    output logic [QID_WIDTH-1:0]       out_qid,
    output logic [ADDRESS_WIDTH-1:0]   out_leaf_index,
    output logic [LEAF_DATA_WIDTH-1:0] out_leaf_data,
    output logic [1:0]                 overflow,
    output logic                       busy
);
    typedef struct packed {
        logic [QID_WIDTH-1:0]     qid;
        logic [ADDRESS_WIDTH-1:0] leaf_index;
    } entry_t;

    localparam int EW = $bits(entry_t);

    fetch_state_t             state;
    fetch_state_t             state_nxt;
    logic [QID_WIDTH-1:0]     qid_cnt [2];
    entry_t                   fifo_din [2];
    entry_t                   fifo_dout [2];
    logic [1:0]               lane_en;
    logic [1:0]               fifo_push;
    logic [1:0]               fifo_pop;
    logic [1:0]               fifo_full;
    logic [1:0]               fifo_empty;
    logic                     any_pending;
    logic                     grant_lane;
    logic                     rr_ptr;
    logic                     issue;
    logic [ADDRESS_WIDTH-1:0] addr_q;

    assign lane_en     = {receiver_two_en, receiver_en};
    assign fifo_din[0] = entry_t'{qid: qid_cnt[0], leaf_index: leaf_index};
    assign fifo_din[1] = entry_t'{qid: qid_cnt[1], leaf_index: leaf_index_two};
    assign fifo_push   = lane_en & {2{!clear}};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        leaf_idx_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .push     (fifo_push[g]),
            .pop      (fifo_pop[g]),
            .din      (fifo_din[g]),
            .dout     (fifo_dout[g]),
            .full     (fifo_full[g]),
            .empty    (fifo_empty[g]),
            .overflow (overflow[g])
        );
    end

    assign any_pending = !(&fifo_empty);
    // The round-robin pointer only matters when both lanes are waiting.
    assign grant_lane  = (fifo_empty == 2'b00) ? rr_ptr :
                         (fifo_empty[0] ? LANE1 : LANE0);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (any_pending) begin
                    issue     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    issue     = any_pending;
                    state_nxt = any_pending ? FETCH : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (clear)
            issue = 1'b0;
    end

    assign fifo_pop[0] = issue && (grant_lane == LANE0);
    assign fifo_pop[1] = issue && (grant_lane == LANE1);
    assign leaf_ren    = issue;
    assign leaf_addr   = issue ? fifo_dout[grant_lane].leaf_index : addr_q;
    assign busy        = any_pending || (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= LANE0;
            addr_q         <= '0;
            out_valid      <= 1'b0;
            out_lane       <= 1'b0;
            out_qid        <= '0;
            out_leaf_index <= '0;
            out_leaf_data  <= '0;
        end else if (clear) begin
            state          <= IDLE;
            rr_ptr         <= LANE0;
            addr_q         <= '0;
            out_valid      <= 1'b0;
            out_lane       <= 1'b0;
            out_qid        <= '0;
            out_leaf_index <= '0;
            out_leaf_data  <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                addr_q         <= fifo_dout[grant_lane].leaf_index;
                rr_ptr         <= ~grant_lane;
                out_lane       <= grant_lane;
                out_qid        <= fifo_dout[grant_lane].qid;
                out_leaf_index <= fifo_dout[grant_lane].leaf_index;
            end
            if (state == FETCH) begin
                out_leaf_data <= leaf_rdata;
                out_valid     <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // qid advances on every enable, dropped or not, so gaps are visible downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qid_cnt[0] <= '0;
            qid_cnt[1] <= '0;
        end else if (clear) begin
            qid_cnt[0] <= '0;
            qid_cnt[1] <= '0;
        end else begin
            for (int l = 0; l < 2; l++)
                if (lane_en[l])
                    qid_cnt[l] <= qid_cnt[l] + QID_WIDTH'(1);
        end
    end

endmodule

// File: doc/leaf_fetch_arbiter.md
Name: leaf_fetch_arbiter

Overview:
- Sits directly downstream of the KD-tree internal-node traversal stage.
- Accepts the two leaf-index result streams, which are qualified by receiver_en and receiver_two_en. Each stream is buffered in its own FIFO.
- Lanes are arbitrated round-robin onto a single leaf-memory read port with 1-cycle read latency.
- Each leaf fetch is presented to the downstream candidate/distance stage over a valid/ready handshake, tagged with lane and per-lane query id.

Parameters:
- ADDRESS_WIDTH, 8, width of leaf index / leaf memory address.
- LEAF_DATA_WIDTH, 64, width of the leaf memory read word.
- QID_WIDTH, 12, width of the per-lane query sequence counter.
- FIFO_DEPTH, 8, entries per lane FIFO; must be a power of 2 and ≥2.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush: FIFOs, qid counters, flags and FSM return to reset state.
- receiver_en  in  1  lane 0 leaf index valid (single-cycle pulse per query).
- leaf_index  in  ADDRESS_WIDTH  lane 0 leaf index.
- receiver_two_en  in  1  lane 1 leaf index valid.
- leaf_index_two  in  ADDRESS_WIDTH  lane 1 leaf index.
- leaf_ren  out  1  leaf memory read strobe.
- leaf_addr  out  ADDRESS_WIDTH  leaf memory read address.
- leaf_rdata  in  LEAF_DATA_WIDTH  leaf memory data, valid the cycle after leaf_ren.
- out_valid  out  1  output record valid.
- out_ready  in  1  downstream accept.
- out_lane  out  1  0 = lane 0, 1 = lane 1.
- out_qid  out  QID_WIDTH  query sequence number within the lane.
- out_leaf_index  out  ADDRESS_WIDTH  leaf index that was fetched.
- out_leaf_data  out  LEAF_DATA_WIDTH  captured leaf_rdata.
- overflow  out  2  sticky per-lane drop flag (bit 0 = lane 0).
- busy  out  1  high when any FIFO is non-empty or the FSM is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) or clear (synchronous):
  - All outputs are 0.
  - FIFOs are empty; qid counters are 0.
  - The round-robin pointer is 0, meaning lane 0 has priority first.
  - FSM is IDLE.
  - clear has priority over every other event in the same cycle.
- Enqueue, per lane independently:
  - On the enable pulse, push {qid_cnt, index} and increment qid_cnt. qid_cnt wraps modulo 2^QID_WIDTH.
  - A push is accepted if the FIFO is not full, or if that FIFO pops in the same cycle.
  - Otherwise the entry is dropped and the lane's overflow bit is set. The bit stays set until reset or clear.
  - qid_cnt increments even on a drop, so the downstream stage can detect gaps.
- The upstream tree has no backpressure, so enqueue never stalls.
- Grant selection:
  - If only one FIFO is non-empty, grant that lane.
  - If both are non-empty, grant the lane named by the round-robin pointer.
  - After each grant, the pointer is set to the other lane.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: if any FIFO is non-empty, pop the granted FIFO, drive leaf_ren=1 and leaf_addr=index, latch {lane, qid, index}, then go to FETCH. Otherwise stay in IDLE with leaf_ren=0.
  - FETCH: capture leaf_rdata into out_leaf_data, set out_valid=1, go to HOLD. leaf_ren=0.
  - HOLD: all out_* fields are stable while out_valid=1 and out_ready=0.
    - On out_valid && out_ready with a FIFO non-empty: pop and issue the next read in the same cycle (leaf_ren=1), drop out_valid, go to FETCH.
    - On out_valid && out_ready with both FIFOs empty: drop out_valid, go to IDLE.
- Throughput is 1 record per 2 cycles with out_ready held high.
- Latency from an enable pulse into an empty, idle block to out_valid is 3 cycles:
  - the push is visible in the FIFO at cycle 1;
  - leaf_ren is driven at cycle 1;
  - out_valid rises at cycle 3 (FETCH happens in cycle 2).
- A push and a pop of the same FIFO in the same cycle keep the occupancy unchanged.
- A same-cycle push to an empty FIFO is not granted until the following cycle; there is no bypass.
- leaf_addr holds its last value when leaf_ren=0.

Decomposition:
- Shared package `leaf_fetch_pkg`: FSM state enum {IDLE, FETCH, HOLD}, localparams LANE0=0 and LANE1=1, and the FIFO entry struct {qid, leaf_index}.
- Sub-module `leaf_idx_fifo`, instantiated twice: synchronous FIFO parameterised by width and depth. Ports: push, pop, din, dout (first-word-fall-through), full, empty, and overflow (sticky). It also takes clear.

Test Plan:
- Single query: receiver_en pulse with leaf_index=0x2A, memory returns 0xDEAD at addr 0x2A, out_ready=1 → leaf_ren at cycle 1 with addr 0x2A; out_valid at cycle 3 with lane=0, qid=0, index=0x2A, data=0xDEAD; busy low afterwards.
- Both lanes pulse in the same cycle (index 0x05 and 0x09), out_ready=1 → lane 0 (0x05) is output first, then lane 1 (0x09); the pointer then favours lane 0.
- Backpressure: out_ready=0 for 10 cycles while 3 lane-0 queries arrive → out_valid stays high with stable fields, no further leaf_ren; after release, qid 0,1,2 are output in order.
- Overflow: out_ready=0 and 10 lane-1 pulses with FIFO_DEPTH=8 → overflow=2'b10 (one entry in the output register, 8 in the FIFO, 1 dropped); outputs then carry qid 0–8, and the next accepted pulse carries qid 10.
- clear asserted in HOLD with both FIFOs partly full → next cycle out_valid=0, busy=0, overflow=0, qid counters at 0; a subsequent pulse is output with qid=0.
- Asynchronous reset mid-FETCH (rst_n dropped between clock edges) → all outputs go to 0 immediately; the block restarts cleanly after release.
